// File: rtl/spi_slave_bridge.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_bridge - SPI slave (any mode/width), oversampled in clk.
//            Optional partial-word abort pulse (frame_err) via SPI_FRAME_ERR_EN.
// Revision : 1.0
// ============================================================================
module spi_slave_bridge #(
    parameter int unsigned DATA_W      = 8,
    parameter bit          CPOL        = 1'b0,
    parameter bit          CPHA        = 1'b0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              byte_sync,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out
`ifdef SPI_FRAME_ERR_EN
    ,
    output logic              frame_err
`endif
);
    localparam int unsigned        c_cnt_w = $clog2(DATA_W);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DATA_W - 1);

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] vld_q, vld_d;
    logic                   armed_q, armed_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_prev_q, cs_prev_d;
    logic [DATA_W-1:0]      rx_q, rx_d;
    logic [DATA_W-1:0]      tx_q, tx_d;
    logic [c_cnt_w-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]      data_in_q, data_in_d;
    logic                   done_q, done_d;
    logic                   byte_sync_q, byte_sync_d;
    logic                   miso_q, miso_d;
`ifdef SPI_FRAME_ERR_EN
    logic                   frame_err_q, frame_err_d;
`endif

    logic sclk_s, cs_s, mosi_s;
    logic leading, trailing, sample_edge, shift_edge, cs_rise, cs_fall;

    always_comb begin
        sclk_s      = sclk_sync_q[SYNC_STAGES-1];
        cs_s        = cs_sync_q[SYNC_STAGES-1];
        mosi_s      = mosi_sync_q[SYNC_STAGES-1];
        leading     = (sclk_prev_q == CPOL) && (sclk_s != CPOL);
        trailing    = (sclk_prev_q != CPOL) && (sclk_s == CPOL);
        sample_edge = armed_q && !cs_s && (CPHA ? trailing : leading);
        shift_edge  = armed_q && !cs_s && (CPHA ? leading : trailing);
        cs_rise     = !cs_prev_q && cs_s;
        cs_fall     = cs_prev_q && !cs_s;

        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        vld_d       = {vld_q[SYNC_STAGES-2:0], 1'b1};
        // Only a cs_n seen high after reset (through a filled synchroniser)
        // arms the slave, so a frame interrupted by reset is never resumed.
        armed_d     = armed_q | (vld_q[SYNC_STAGES-1] & cs_s);
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
        rx_d        = rx_q;
        tx_d        = tx_q;
        bit_cnt_d   = bit_cnt_q;
        data_in_d   = data_in_q;
        done_d      = 1'b0;
        byte_sync_d = done_q;

        if (cs_rise) begin
            bit_cnt_d = '0;
            rx_d      = '0;
        end else if (cs_fall && armed_q) begin
            bit_cnt_d = '0;
            rx_d      = '0;
            if (!CPHA) tx_d = data_out;
        end else if (sample_edge) begin
            rx_d = {rx_q[DATA_W-2:0], mosi_s};
            if (bit_cnt_q == c_last) begin
                data_in_d = rx_d;
                bit_cnt_d = '0;
                done_d    = 1'b1;
                if (!CPHA) tx_d = data_out;
            end else begin
                bit_cnt_d = bit_cnt_q + c_cnt_w'(1);
            end
        end else if (shift_edge) begin
            // CPHA=1 loads the word on its first shift edge; CPHA=0 already
            // holds the MSB on the line and must not shift it away.
            if (CPHA && (bit_cnt_q == '0)) tx_d = data_out;
            else if (CPHA || (bit_cnt_q != '0)) tx_d = {tx_q[DATA_W-2:0], 1'b0};
        end

        miso_d = !cs_s & tx_d[DATA_W-1];
`ifdef SPI_FRAME_ERR_EN
        frame_err_d = cs_rise && (bit_cnt_q != '0);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= {SYNC_STAGES{CPOL}};
            cs_sync_q   <= {SYNC_STAGES{1'b1}};
            mosi_sync_q <= '0;
            vld_q       <= '0;
            armed_q     <= 1'b0;
            sclk_prev_q <= CPOL;
            cs_prev_q   <= 1'b1;
            rx_q        <= '0;
            tx_q        <= '0;
            bit_cnt_q   <= '0;
            data_in_q   <= '0;
            done_q      <= 1'b0;
            byte_sync_q <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            vld_q       <= vld_d;
            armed_q     <= armed_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            bit_cnt_q   <= bit_cnt_d;
            data_in_q   <= data_in_d;
            done_q      <= done_d;
            byte_sync_q <= byte_sync_d;
            miso_q      <= miso_d;
        end
    end

`ifdef SPI_FRAME_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_err_q <= 1'b0;
        else        frame_err_q <= frame_err_d;
    end
    assign frame_err = frame_err_q;
`endif

    assign miso      = miso_q;
    assign byte_sync = byte_sync_q;
    assign data_in   = data_in_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_bridge - randomized scoreboard bench, 5 DUT configs.
// Revision : 1.0
// ============================================================================
module tb_spi_slave_bridge;
    localparam int HALF = 8;
    localparam int SS   = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [4:0]  sclk_p, cs_p, mosi_p, miso_w, bs_w;
    logic [7:0]  dout8 [4];
    logic [7:0]  din8  [4];
    logic [15:0] dout16, din16;
`ifdef SPI_FRAME_ERR_EN
    logic [4:0]  fe_w;
    int          fe_exp  [5];
    int          fe_seen [5];
`endif

    // DUT g: 8-bit, SPI mode g (CPOL = g/2, CPHA = g%2)
    for (genvar g = 0; g < 4; g++) begin : g_w8
        spi_slave_bridge #(
            .DATA_W(8), .CPOL((g / 2) == 1), .CPHA((g % 2) == 1), .SYNC_STAGES(SS)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .sclk(sclk_p[g]), .cs_n(cs_p[g]),
            .mosi(mosi_p[g]), .miso(miso_w[g]), .byte_sync(bs_w[g]),
            .data_in(din8[g]), .data_out(dout8[g])
`ifdef SPI_FRAME_ERR_EN
            , .frame_err(fe_w[g])
`endif
        );
    end

    spi_slave_bridge #(
        .DATA_W(16), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(SS)
    ) u_w16 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk_p[4]), .cs_n(cs_p[4]),
        .mosi(mosi_p[4]), .miso(miso_w[4]), .byte_sync(bs_w[4]),
        .data_in(din16), .data_out(dout16)
`ifdef SPI_FRAME_ERR_EN
        , .frame_err(fe_w[4])
`endif
    );

    typedef struct { int idx; logic [15:0] w; } exp_t;
    exp_t        sb[$];
    logic [15:0] last_word [5];
    logic [15:0] mw [4];
    logic [15:0] dw [4];
    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic logic cpol_of(input int i);  return (i == 2) || (i == 3); endfunction
    function automatic logic cpha_of(input int i);  return (i == 1) || (i == 3); endfunction
    function automatic int   width_of(input int i); return (i == 4) ? 16 : 8;    endfunction
    function automatic logic [15:0] mask(input int w); return (w == 16) ? 16'hFFFF : 16'h00FF; endfunction

    function automatic logic [15:0] get_din(input int i);
        return (i == 4) ? din16 : {8'h00, din8[i]};
    endfunction

    task automatic set_dout(input int i, input logic [15:0] v);
        if (i == 4) dout16 = v;
        else        dout8[i] = v[7:0];
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard monitor: every byte_sync pops one expected word
    logic [4:0] bs_prev;
    exp_t       e;
    always @(negedge clk) begin
        if (!rst_n) begin
            bs_prev <= '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (bs_w[i]) begin
                    check("byte_sync_gap", {15'b0, bs_prev[i]}, 16'h0000);
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_byte_sync: dut%0d data_in=%h expected no pulse", i, get_din(i));
                    end else begin
                        e = sb.pop_front();
                        check("sb_dut_index", 16'(i), 16'(e.idx));
                        check("data_in", get_din(i), e.w);
                    end
                end
`ifdef SPI_FRAME_ERR_EN
                if (fe_w[i]) fe_seen[i]++;
`endif
            end
            bs_prev <= bs_w;
        end
    end

    // One SPI bit as the master sees it; rd is miso at the sampling edge
    task automatic sclk_bit(input int i, input logic b, output logic rd);
        if (!cpha_of(i)) begin
            mosi_p[i] = b;
            wait_clk(HALF);
            rd = miso_w[i];
            sclk_p[i] = ~cpol_of(i);
            wait_clk(HALF);
            sclk_p[i] = cpol_of(i);
        end else begin
            sclk_p[i] = ~cpol_of(i);
            mosi_p[i] = b;
            wait_clk(HALF);
            rd = miso_w[i];
            sclk_p[i] = cpol_of(i);
            wait_clk(HALF);
        end
    endtask

    // Frame of nbits on DUT i, words mw[], data_out per word dw[]
    task automatic frame(input int i, input int nbits);
        int          w;
        logic        rd;
        logic [15:0] got;
        logic [15:0] exp_rd;
        w   = width_of(i);
        got = '0;
        for (int k = 0; k < nbits / w; k++) begin
            sb.push_back('{idx: i, w: mw[k]});
            last_word[i] = mw[k];
        end
`ifdef SPI_FRAME_ERR_EN
        if (nbits % w != 0) fe_exp[i]++;
`endif
        set_dout(i, dw[0]);
        wait_clk(2);
        cs_p[i] = 1'b0;
        wait_clk(HALF);
        for (int b = 0; b < nbits; b++) begin
            int k;
            int pos;
            k   = b / w;
            pos = w - 1 - (b % w);
            if (b % w == 0) set_dout(i, dw[k]);
            sclk_bit(i, mw[k][pos], rd);
            got = {got[14:0], rd};
            if (b % w == w - 1) begin
                // CPHA=0 reloads at the previous word's completion; CPHA=1
                // loads on the word's own first shift edge.
                exp_rd = (k == 0 || cpha_of(i)) ? dw[k] : dw[k-1];
                check("master_read", got & mask(w), exp_rd & mask(w));
            end
        end
        wait_clk(HALF);
        cs_p[i] = 1'b1;
        wait_clk(4 * HALF);
        check("sb_drained", 16'(sb.size()), 16'h0000);
        check("data_in_hold", get_din(i), last_word[i]);
        check("miso_idle", {15'b0, miso_w[i]}, 16'h0000);
`ifdef SPI_FRAME_ERR_EN
        check("frame_err_count", 16'(fe_seen[i]), 16'(fe_exp[i]));
`endif
    endtask

    task automatic check_reset_outputs();
        for (int i = 0; i < 5; i++) begin
            check("rst_byte_sync", {15'b0, bs_w[i]}, 16'h0000);
            check("rst_data_in", get_din(i), 16'h0000);
            check("rst_miso", {15'b0, miso_w[i]}, 16'h0000);
        end
    endtask

    task automatic clear_model();
        sb.delete();
        for (int i = 0; i < 5; i++) begin
            last_word[i] = '0;
`ifdef SPI_FRAME_ERR_EN
            fe_exp[i]  = 0;
            fe_seen[i] = 0;
`endif
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic rd;
        rst_n  = 1'b0;
        sclk_p = 5'b01100;
        cs_p   = 5'b11111;
        mosi_p = '0;
        dout16 = '0;
        for (int i = 0; i < 4; i++) dout8[i] = '0;
        clear_model();
        wait_clk(5);
        check_reset_outputs();
        rst_n = 1'b1;
        wait_clk(10);

        // Mode 0 basic word, master reads 0x3C
        mw[0] = 16'h00A5; dw[0] = 16'h003C;
        frame(0, 8);
        // Modes 1..3
        for (int i = 1; i < 4; i++) begin
            mw[0] = 16'h005A; dw[0] = 16'h00C3;
            frame(i, 8);
        end
        // Two words in one frame, data_out changed between words
        mw[0] = 16'h0012; mw[1] = 16'h0034; dw[0] = 16'h003C; dw[1] = 16'h0099;
        frame(0, 16);
        // Abort after 5 bits, then a clean frame
        mw[0] = 16'h00FF; dw[0] = 16'h0000;
        frame(0, 5);
        mw[0] = 16'h0081; dw[0] = 16'h0042;
        frame(0, 8);
        // 16-bit word
        mw[0] = 16'hBEEF; dw[0] = 16'h1234;
        frame(4, 16);

        // Reset mid-frame; stray bits before a cs_n toggle are ignored
        dw[0] = 16'h0000;
        set_dout(0, dw[0]);
        cs_p[0] = 1'b0;
        wait_clk(HALF);
        for (int b = 0; b < 3; b++) sclk_bit(0, 1'b1, rd);
        rst_n = 1'b0;
        wait_clk(2);
        check_reset_outputs();
        clear_model();
        rst_n = 1'b1;
        wait_clk(10);
        for (int b = 0; b < 8; b++) sclk_bit(0, 1'b1, rd);
        wait_clk(HALF);
        cs_p[0] = 1'b1;
        wait_clk(4 * HALF);
        check("post_rst_stray", get_din(0), 16'h0000);
        mw[0] = 16'h0077; dw[0] = 16'h00E1;
        frame(0, 8);

        // Randomized frames across all configurations
        for (int it = 0; it < 24; it++) begin
            int i;
            int w;
            int nb;
            i  = int'($urandom_range(0, 4));
            w  = width_of(i);
            nb = w * int'($urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) nb = nb - w + int'($urandom_range(1, w - 1));
            for (int k = 0; k < 4; k++) begin
                mw[k] = 16'($urandom) & mask(w);
                dw[k] = 16'($urandom) & mask(w);
            end
            frame(i, nb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
